// File: rtl/mfp_mac_seq_mc_pkg.sv
// ============================================================================
// Module   : mfp_mac_seq_mc_pkg
// Purpose  : Shared fixed-point width helpers for the MFP arithmetic blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfp_mac_seq_mc_pkg;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A signed product loses one redundant sign bit; an unsigned one keeps the full width.
    function automatic int prod_w(input int in1w, input int in2w, input int is_unsigned);
        return (is_unsigned != 0) ? (in1w + in2w) : (in1w + in2w - 1);
    endfunction

    function automatic int acc_w(input int pw, input int tap_l);
        return pw + clog2(tap_l);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/MFP_Multi.sv
// ============================================================================
// Module   : MFP_Multi
// Purpose  : Combinational signed/unsigned multiplier producing OutW bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module MFP_Multi #(
    parameter int In1W       = 8,
    parameter int In2W       = 8,
    parameter int isUnsigned = 0,
    parameter int OutW       = 15
) (
    input  logic [In1W-1:0] dataa,
    input  logic [In2W-1:0] datab,
    output logic [OutW-1:0] result
);

    logic [OutW-1:0] w_a;
    logic [OutW-1:0] w_b;

    // Operands are widened to the result width so the modulo-2**OutW product is exact.
    always_comb begin
        if (isUnsigned != 0) begin
            w_a = OutW'(dataa);
            w_b = OutW'(datab);
        end else begin
            w_a = OutW'($signed(dataa));
            w_b = OutW'($signed(datab));
        end
        result = w_a * w_b;
    end

endmodule

`default_nettype wire

// File: rtl/mfp_round_sat.sv
// ============================================================================
// Module   : mfp_round_sat
// Purpose  : Floor right-shift followed by saturation or truncation to OutW.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_round_sat #(
    parameter int InW        = 17,
    parameter int ShiftR     = 0,
    parameter int OutW       = 16,
    parameter int isUnsigned = 0,
    parameter int isSat      = 1
) (
    input  logic [InW-1:0]  din,
    output logic [OutW-1:0] dout
);

    // One spare bit keeps unsigned values positive in the signed domain.
    localparam int c_W = ((InW > OutW) ? InW : OutW) + 1;

    logic signed [c_W-1:0] w_ext;
    logic signed [c_W-1:0] w_shift;
    logic signed [c_W-1:0] w_max;
    logic signed [c_W-1:0] w_min;

    always_comb begin
        if (isUnsigned != 0) begin
            w_ext = c_W'(din);
        end else begin
            w_ext = c_W'($signed(din));
        end
        w_shift = w_ext >>> ShiftR;

        w_max           = '0;
        w_max[OutW-1:0] = '1;
        w_min           = '0;
        if (isUnsigned == 0) begin
            w_max[OutW-1] = 1'b0;
            w_min         = ~w_max;
        end

        if (isSat == 0) begin
            dout = w_shift[OutW-1:0];
        end else if (w_shift > w_max) begin
            dout = w_max[OutW-1:0];
        end else if (w_shift < w_min) begin
            dout = w_min[OutW-1:0];
        end else begin
            dout = w_shift[OutW-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mfp_mac_seq_mc.sv
// ============================================================================
// Module   : mfp_mac_seq_mc
// Purpose  : Multi-channel sequential MAC; one result per TapL beats per channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_mac_seq_mc
    import mfp_mac_seq_mc_pkg::*;
#(
    parameter int In1W       = 8,
    parameter int In2W       = In1W,
    parameter int ChN        = 4,
    parameter int TapL       = 16,
    parameter int ShiftR     = 0,
    parameter int OutW       = 16,
    parameter int isUnsigned = 0,
    parameter int isSat      = 1
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [idx_w(ChN)-1:0]     in_ch,
    input  logic [In1W-1:0]           In1,
    input  logic [In2W-1:0]           In2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [idx_w(ChN)-1:0]     out_ch,
    output logic [OutW-1:0]           acc_sum_rounded
);

    localparam int c_PROD_W = prod_w(In1W, In2W, isUnsigned);
    localparam int c_ACC_W  = acc_w(c_PROD_W, TapL);
    localparam int c_CH_W   = idx_w(ChN);
    localparam int c_CNT_W  = idx_w(TapL);

    logic [c_ACC_W-1:0]  r_acc [ChN];
    logic [c_CNT_W-1:0]  r_cnt [ChN];
    logic                r_out_valid;
    logic [c_CH_W-1:0]   r_out_ch;
    logic [OutW-1:0]     r_out_data;

    logic [c_PROD_W-1:0] w_prod;
    logic [c_ACC_W-1:0]  w_prod_ext;
    logic [c_ACC_W-1:0]  w_acc_cur;
    logic [c_ACC_W-1:0]  w_acc_next;
    logic [c_CNT_W-1:0]  w_cnt_cur;
    logic [OutW-1:0]     w_result;
    logic                w_ch_ok;
    logic                w_accept;
    logic                w_last;

    MFP_Multi #(
        .In1W       (In1W),
        .In2W       (In2W),
        .isUnsigned (isUnsigned),
        .OutW       (c_PROD_W)
    ) u_mult (
        .dataa  (In1),
        .datab  (In2),
        .result (w_prod)
    );

    always_comb begin
        if (isUnsigned != 0) begin
            w_prod_ext = c_ACC_W'(w_prod);
        end else begin
            w_prod_ext = c_ACC_W'($signed(w_prod));
        end
    end

    // Extra bit on both sides keeps the range test meaningful when ChN is a power of two.
    assign w_ch_ok    = ({1'b0, in_ch} < (c_CH_W + 1)'(ChN));
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready && w_ch_ok;
    assign w_cnt_cur  = r_cnt[in_ch];
    assign w_acc_cur  = r_acc[in_ch];
    assign w_last     = (w_cnt_cur == c_CNT_W'(TapL - 1));
    assign w_acc_next = (w_cnt_cur == '0) ? w_prod_ext : (w_acc_cur + w_prod_ext);

    mfp_round_sat #(
        .InW        (c_ACC_W),
        .ShiftR     (ShiftR),
        .OutW       (OutW),
        .isUnsigned (isUnsigned),
        .isSat      (isSat)
    ) u_round_sat (
        .din  (w_acc_next),
        .dout (w_result)
    );

    // Accumulators need no reset: a zero tap count always reloads them.
    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int i = 0; i < ChN; i++) begin
                r_cnt[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_acc[in_ch] <= w_acc_next;
                r_cnt[in_ch] <= w_last ? '0 : (w_cnt_cur + 1'b1);
                if (w_last) begin
                    r_out_valid <= 1'b1;
                    r_out_ch    <= in_ch;
                    r_out_data  <= w_result;
                end
            end
        end
    end

    assign out_valid       = r_out_valid;
    assign out_ch          = r_out_ch;
    assign acc_sum_rounded = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_mfp_mac_seq_mc.sv
// ============================================================================
// Module   : tb_mfp_mac_seq_mc
// Purpose  : Self-checking bench for mfp_mac_seq_mc (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mfp_mac_seq_mc;

    logic clk = 1'b0;
    logic aclr;
    always #5 clk = ~clk;

    // Shared stimulus for the three 2-channel / 4-tap signed instances
    logic       in_valid, out_ready;
    logic [0:0] in_ch;
    logic [7:0] in1, in2;

    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [0:0] a_out_ch, b_out_ch, c_out_ch;
    logic [15:0] a_acc;
    logic [7:0]  b_acc, c_acc;

    // Unsigned 3-channel / 3-tap / shift-2 instance for randomized checks
    logic       d_in_valid, d_out_ready, d_in_ready, d_out_valid;
    logic [1:0] d_in_ch, d_out_ch;
    logic [7:0] d_in1, d_acc;
    logic [5:0] d_in2;

    mfp_mac_seq_mc #(.In1W(8), .ChN(2), .TapL(4), .ShiftR(0), .OutW(16), .isUnsigned(0), .isSat(1)) u_a (
        .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(a_in_ready), .in_ch(in_ch),
        .In1(in1), .In2(in2), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ch(a_out_ch), .acc_sum_rounded(a_acc));

    mfp_mac_seq_mc #(.In1W(8), .ChN(2), .TapL(4), .ShiftR(0), .OutW(8), .isUnsigned(0), .isSat(1)) u_b (
        .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(b_in_ready), .in_ch(in_ch),
        .In1(in1), .In2(in2), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ch(b_out_ch), .acc_sum_rounded(b_acc));

    mfp_mac_seq_mc #(.In1W(8), .ChN(2), .TapL(4), .ShiftR(0), .OutW(8), .isUnsigned(0), .isSat(0)) u_c (
        .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(c_in_ready), .in_ch(in_ch),
        .In1(in1), .In2(in2), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_ch(c_out_ch), .acc_sum_rounded(c_acc));

    mfp_mac_seq_mc #(.In1W(8), .In2W(6), .ChN(3), .TapL(3), .ShiftR(2), .OutW(8), .isUnsigned(1), .isSat(1)) u_d (
        .clk(clk), .aclr(aclr), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_ch(d_in_ch),
        .In1(d_in1), .In2(d_in2), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_ch(d_out_ch), .acc_sum_rounded(d_acc));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int a;  int b;  int ch;
        bit ev; int ech; int ea; int eb; int ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int a, input int b, input int ch, input bit ev,
                                input int ea, input int eb, input int ec);
        vec_t v;
        v.a = a; v.b = b; v.ch = ch; v.ev = ev; v.ech = ch; v.ea = ea; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic beat(input int a, input int b, input int ch);
        @(negedge clk);
        in_valid = 1'b1;
        in1      = 8'(a);
        in2      = 8'(b);
        in_ch    = 1'(ch);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Behavioural reference for the unsigned instance: per-channel running sums
    typedef struct { int ch; int val; } res_t;
    res_t expq[$];
    int   m_sum [3];
    int   m_cnt [3];
    bit   run_rand = 1'b0;
    bit   prev_v, prev_r;
    int   prev_ch, prev_data;
    int   n_rand_res = 0;

    always @(posedge clk) begin
        if (run_rand) begin
            check("rand_in_ready", longint'(d_in_ready), longint'(!d_out_valid || d_out_ready));
            if (prev_v && !prev_r) begin
                check("rand_hold_valid", longint'(d_out_valid), 1);
                check("rand_hold_ch",    longint'(d_out_ch), prev_ch);
                check("rand_hold_data",  longint'(d_acc), prev_data);
            end
            if (d_out_valid && d_out_ready) begin
                if (expq.size() == 0) begin
                    check("rand_unexpected_result", 1, 0);
                end else begin
                    res_t e;
                    e = expq.pop_front();
                    check("rand_ch",   longint'(d_out_ch), e.ch);
                    check("rand_data", longint'(d_acc), e.val);
                    n_rand_res++;
                end
            end
            if (d_in_valid && d_in_ready && int'(d_in_ch) < 3) begin
                int ch, p, v;
                res_t r;
                ch = int'(d_in_ch);
                p  = int'(d_in1) * int'(d_in2);
                m_sum[ch] = (m_cnt[ch] == 0) ? p : m_sum[ch] + p;
                m_cnt[ch]++;
                if (m_cnt[ch] == 3) begin
                    m_cnt[ch] = 0;
                    v = m_sum[ch] / 4;
                    r.ch  = ch;
                    r.val = (v > 255) ? 255 : v;
                    expq.push_back(r);
                end
            end
            prev_v    = d_out_valid;
            prev_r    = d_out_ready;
            prev_ch   = int'(d_out_ch);
            prev_data = int'(d_acc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        aclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_ch = '0; in1 = '0; in2 = '0;
        d_in_valid = 1'b0; d_out_ready = 1'b1; d_in_ch = '0; d_in1 = '0; d_in2 = '0;

        // Reset state
        @(negedge clk); aclr = 1'b1;
        @(posedge clk); #1;
        aclr = 1'b0;
        check("rst_a_out_valid", longint'(a_out_valid), 0);
        check("rst_a_in_ready",  longint'(a_in_ready), 1);
        check("rst_a_out_ch",    longint'(a_out_ch), 0);
        check("rst_a_acc",       longint'(a_acc), 0);
        check("rst_b_out_valid", longint'(b_out_valid), 0);
        check("rst_c_out_valid", longint'(c_out_valid), 0);
        check("rst_d_out_valid", longint'(d_out_valid), 0);
        check("rst_d_in_ready",  longint'(d_in_ready), 1);
        check("rst_d_acc",       longint'(d_acc), 0);

        // Single channel, interleaved channels, saturation/truncation extremes
        for (int i = 0; i < 3; i++) tbl.push_back(mk(10, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(10, 3, 0, 1, 120, 120, 120));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(10, 3, 0, 0, 0, 0, 0));
            tbl.push_back(mk(-5, 7, 1, 0, 0, 0, 0));
        end
        tbl.push_back(mk(10, 3, 0, 1, 120, 120, 120));
        tbl.push_back(mk(-5, 7, 1, 1, -140, -128, 116));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(127, 127, 0, 0, 0, 0, 0));
        tbl.push_back(mk(127, 127, 0, 1, 32767, 127, 4));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(-128, 127, 0, 0, 0, 0, 0));
        tbl.push_back(mk(-128, 127, 0, 1, -32768, -128, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i].a, tbl[i].b, tbl[i].ch);
            check($sformatf("tbl%0d_valid", i), longint'(a_out_valid), longint'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_ch", i),    longint'(a_out_ch), tbl[i].ech);
                check($sformatf("tbl%0d_a", i),     longint'($signed(a_acc)), tbl[i].ea);
                check($sformatf("tbl%0d_b_sat", i), longint'($signed(b_acc)), tbl[i].eb);
                check($sformatf("tbl%0d_c_trn", i), longint'($signed(c_acc)), tbl[i].ec);
            end
        end

        // Back-pressure: result held for 5 cycles while a ch1 beat waits
        for (int i = 0; i < 3; i++) beat(1, 2, 0);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in1 = 8'd1; in2 = 8'd2; in_ch = 1'b0;
        @(posedge clk); #1;
        in1 = 8'd3; in2 = 8'd3; in_ch = 1'b1;
        check("stall_first_valid", longint'(a_out_valid), 1);
        check("stall_first_data",  longint'(a_acc), 8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_in_ready", longint'(a_in_ready), 0);
            check("stall_hold_valid", longint'(a_out_valid), 1);
            check("stall_hold_data",  longint'(a_acc), 8);
            check("stall_hold_ch",    longint'(a_out_ch), 0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall_release_retired", longint'(a_out_valid), 0);
        for (int i = 0; i < 3; i++) beat(3, 3, 1);
        check("stall_after_valid", longint'(a_out_valid), 1);
        check("stall_after_ch",    longint'(a_out_ch), 1);
        check("stall_after_data",  longint'(a_acc), 36);

        // Reset mid-frame with a simultaneous beat
        beat(10, 3, 0);
        beat(10, 3, 0);
        @(negedge clk);
        aclr = 1'b1; in_valid = 1'b1; in1 = 8'd50; in2 = 8'd50; in_ch = 1'b0;
        @(posedge clk); #1;
        aclr = 1'b0; in_valid = 1'b0;
        check("midrst_out_valid", longint'(a_out_valid), 0);
        check("midrst_in_ready",  longint'(a_in_ready), 1);
        for (int i = 0; i < 3; i++) beat(1, 1, 0);
        check("midrst_no_early", longint'(a_out_valid), 0);
        beat(1, 1, 0);
        check("midrst_valid", longint'(a_out_valid), 1);
        check("midrst_data",  longint'(a_acc), 4);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3; c++) begin m_sum[c] = 0; m_cnt[c] = 0; end
        prev_v = 1'b0; prev_r = 1'b1;
        @(negedge clk);
        run_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            d_in_valid  = ($urandom % 4) != 0;
            d_out_ready = ($urandom % 3) != 0;
            d_in_ch     = 2'($urandom_range(0, 3));
            d_in1       = 8'(($urandom % 2) ? $urandom_range(0, 40) : $urandom_range(0, 255));
            d_in2       = 6'(($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 63));
            @(negedge clk);
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        for (int k = 0; k < 20 && (expq.size() != 0 || d_out_valid); k++) @(negedge clk);
        @(negedge clk);
        run_rand = 1'b0;
        check("rand_drain", longint'(expq.size()), 0);
        check("rand_results_seen", longint'(n_rand_res > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
